risk_monitor_mc: RTL and testbench

// Parametrised multi-channel driver-risk monitor; next generation of the single-path monitor.
// - Scores NUM_FEAT signed features with programmable weights.
// - Averages the score over a 2^WIN_LOG2 window.
// - Runs a warn/emergency FSM with dwell and hysteresis, and raises maskable, sticky,
//   ack-cleared interrupts to the host.

---
 rtl/risk_monitor_mc_pkg.sv | 24 ++
 rtl/risk_monitor_mc_score_window.sv | 50 +++++
 rtl/risk_monitor_mc.sv | 214 +++++++++++++++++++++
 tb/tb_risk_monitor_mc.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risk_monitor_mc_pkg.sv
// Shared definitions for the multi-channel risk monitor: state encodings,
// configuration address offsets, threshold reset values and a clamp helper.
package risk_monitor_mc_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_WARN   = 2'd1,
        ST_EMER   = 2'd2
    } state_t;

    // Threshold registers sit directly above the weight block in the address map.
    localparam int CFG_WARN_OFS = 0;
    localparam int CFG_EMER_OFS = 1;

    localparam logic [7:0] WARN_TH_RST = 8'd64;
    localparam logic [7:0] EMER_TH_RST = 8'd128;

    function automatic logic [7:0] sat0(input logic [7:0] x, input int unsigned d);
        int diff;
        diff = int'(x) - int'(d);
        return (diff < 0) ? 8'd0 : 8'(diff);
    endfunction

endpackage

// File: rtl/risk_monitor_mc_score_window.sv
// Circular window of recent scores with a running sum; emits the window mean
// one cycle after each new score. The window starts zero-filled.
module risk_monitor_mc_score_window #(
    parameter int WIN_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld,
    input  logic [7:0] in_score,
    output logic [7:0] avg,
    output logic       avg_vld
);

    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int SUM_W = 8 + WIN_LOG2;

    logic [7:0]          win_reg [DEPTH];
    logic [WIN_LOG2-1:0] wr_ptr_reg;
    logic [SUM_W-1:0]    sum_reg;
    logic [SUM_W-1:0]    sum_next;
    logic [7:0]          avg_reg;
    logic                avg_vld_reg;

    // The slot being overwritten holds the oldest sample.
    assign sum_next = sum_reg + SUM_W'(in_score) - SUM_W'(win_reg[wr_ptr_reg]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                win_reg[k] <= '0;
            end
            wr_ptr_reg  <= '0;
            sum_reg     <= '0;
            avg_reg     <= '0;
            avg_vld_reg <= 1'b0;
        end else begin
            avg_vld_reg <= in_vld;
            if (in_vld) begin
                win_reg[wr_ptr_reg] <= in_score;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
                sum_reg             <= sum_next;
                avg_reg             <= 8'(sum_next >> WIN_LOG2);
            end
        end
    end

    assign avg     = avg_reg;
    assign avg_vld = avg_vld_reg;

endmodule

// File: rtl/risk_monitor_mc.sv
// Multi-channel driver-risk monitor: weighted feature score, windowed mean,
// NORMAL/WARN/EMER supervision with dwell and hysteresis, sticky maskable irqs.
module risk_monitor_mc
    import risk_monitor_mc_pkg::*;
#(
    parameter int NUM_FEAT    = 4,
    parameter int DW          = 8,
    parameter int WW          = 8,
    parameter int WIN_LOG2    = 3,
    parameter int DWELL       = 4,
    parameter int HYST        = 8,
    parameter int SCORE_SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_addr,
    input  logic [15:0]            cfg_wdata,
    input  logic                   in_valid,
    input  logic [NUM_FEAT*DW-1:0] feat,
    input  logic [1:0]             irq_ack,
    input  logic [1:0]             irq_mask,
    output logic [7:0]             score,
    output logic                   score_vld,
    output logic [7:0]             avg,
    output logic [1:0]             state,
    output logic [1:0]             irq
);

    localparam int PW  = DW + WW;
    localparam int SW  = PW + $clog2(NUM_FEAT);
    localparam int DCW = $clog2(DWELL + 1);

    logic signed [WW-1:0] weight_reg [NUM_FEAT];
    logic [7:0]           warn_th_reg;
    logic [7:0]           emer_th_reg;
    logic                 unused_cfg;

    logic signed [PW-1:0] prod_c   [NUM_FEAT];
    logic signed [PW-1:0] prod_reg [NUM_FEAT];
    logic                 v1_reg;

    logic signed [SW-1:0] sum_c;
    logic [SW-1:0]        mag_c;
    logic [SW-1:0]        shifted_c;
    logic [7:0]           score_c;
    logic [7:0]           score_reg;
    logic                 score_vld_reg;
    logic [7:0]           byp_score_reg;

    logic [7:0]           avg_val;
    logic                 avg_vld;

    state_t               state_reg, state_next;
    logic [DCW-1:0]       dwell_reg, dwell_next;
    logic [1:0]           irq_reg, irq_next;
    logic                 emer_hit;
    logic [7:0]           warn_exit;
    logic [7:0]           emer_exit;
    logic                 warn_evt;
    logic                 emer_evt;

    assign unused_cfg = ^cfg_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_FEAT; k++) begin
                weight_reg[k] <= '0;
            end
            warn_th_reg <= WARN_TH_RST;
            emer_th_reg <= EMER_TH_RST;
        end else if (cfg_we) begin
            for (int k = 0; k < NUM_FEAT; k++) begin
                if (cfg_addr == 4'(k)) begin
                    weight_reg[k] <= cfg_wdata[WW-1:0];
                end
            end
            if (cfg_addr == 4'(NUM_FEAT + CFG_WARN_OFS)) begin
                warn_th_reg <= cfg_wdata[7:0];
            end
            if (cfg_addr == 4'(NUM_FEAT + CFG_EMER_OFS)) begin
                emer_th_reg <= cfg_wdata[7:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_FEAT; gi++) begin : g_prod
            assign prod_c[gi] = PW'($signed(feat[gi*DW +: DW])) * PW'(weight_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_reg <= 1'b0;
            for (int k = 0; k < NUM_FEAT; k++) begin
                prod_reg[k] <= '0;
            end
        end else begin
            v1_reg <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < NUM_FEAT; k++) begin
                    prod_reg[k] <= prod_c[k];
                end
            end
        end
    end

    // Sum is sized with clog2(NUM_FEAT) guard bits, so it cannot overflow.
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            sum_c = sum_c + SW'(prod_reg[k]);
        end
        mag_c     = sum_c[SW-1] ? -sum_c : sum_c;
        shifted_c = mag_c >> SCORE_SHIFT;
        score_c   = (shifted_c > SW'(255)) ? 8'd255 : shifted_c[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_reg     <= '0;
            score_vld_reg <= 1'b0;
            byp_score_reg <= '0;
        end else begin
            score_vld_reg <= v1_reg;
            if (v1_reg) begin
                score_reg <= score_c;
            end
            // Keeps the raw score aligned with its avg for the bypass check.
            if (score_vld_reg) begin
                byp_score_reg <= score_reg;
            end
        end
    end

    risk_monitor_mc_score_window #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (score_vld_reg),
        .in_score (score_reg),
        .avg      (avg_val),
        .avg_vld  (avg_vld)
    );

    assign emer_hit  = (avg_val >= emer_th_reg) || (byp_score_reg >= emer_th_reg);
    assign warn_exit = sat0(warn_th_reg, HYST);
    assign emer_exit = sat0(emer_th_reg, HYST);

    always_comb begin
        state_next = state_reg;
        dwell_next = dwell_reg;
        warn_evt   = 1'b0;
        emer_evt   = 1'b0;
        if (avg_vld) begin
            if (emer_hit) begin
                state_next = ST_EMER;
            end else begin
                case (state_reg)
                    ST_NORMAL: begin
                        if (avg_val >= warn_th_reg) begin
                            if (dwell_reg >= DCW'(DWELL - 1)) begin
                                state_next = ST_WARN;
                            end else begin
                                dwell_next = dwell_reg + 1'b1;
                            end
                        end else begin
                            dwell_next = '0;
                        end
                    end
                    ST_WARN: begin
                        if (avg_val < warn_exit) begin
                            state_next = ST_NORMAL;
                        end
                    end
                    ST_EMER: begin
                        if (avg_val < emer_exit) begin
                            state_next = (avg_val < warn_exit) ? ST_NORMAL : ST_WARN;
                        end
                    end
                    default: state_next = ST_NORMAL;
                endcase
            end
            if (state_next != ST_NORMAL) begin
                dwell_next = '0;
            end
            warn_evt = (state_reg == ST_NORMAL) && (state_next == ST_WARN);
            emer_evt = (state_reg != ST_EMER) && (state_next == ST_EMER);
        end
        // A new event beats an ack in the same cycle; masked events are dropped.
        irq_next = (irq_reg & ~irq_ack) | ({emer_evt, warn_evt} & ~irq_mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_NORMAL;
            dwell_reg <= '0;
            irq_reg   <= '0;
        end else begin
            state_reg <= state_next;
            dwell_reg <= dwell_next;
            irq_reg   <= irq_next;
        end
    end

    assign score     = score_reg;
    assign score_vld = score_vld_reg;
    assign avg       = avg_val;
    assign state     = state_reg;
    assign irq       = irq_reg;

endmodule

// File: tb/tb_risk_monitor_mc.sv
// Randomised bench for risk_monitor_mc, compared every cycle against a
// transaction-level model (score arithmetic, window queue, rule-based FSM).
module tb_risk_monitor_mc;

    localparam int NF    = 4;
    localparam int DWELL = 4;
    localparam int HYST  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [15:0]   cfg_wdata = '0;
    logic          in_valid = 1'b0;
    logic [NF*8-1:0] feat = '0;
    logic [1:0]    irq_ack = '0;
    logic [1:0]    irq_mask = '0;
    logic [7:0]    score;
    logic          score_vld;
    logic [7:0]    avg;
    logic [1:0]    state;
    logic [1:0]    irq;
    logic [20:0]   obs;

    always #5 clk = ~clk;

    risk_monitor_mc dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .in_valid  (in_valid),
        .feat      (feat),
        .irq_ack   (irq_ack),
        .irq_mask  (irq_mask),
        .score     (score),
        .score_vld (score_vld),
        .avg       (avg),
        .state     (state),
        .irq       (irq)
    );

    assign obs = {score, score_vld, avg, state, irq};

    int vectors = 0;
    int miscompares = 0;
    int ecount = 0;

    typedef struct {
        int cap;
        int s;
        int a;
    } samp_t;

    int        m_w [NF];
    int        m_warn, m_emer, m_state, m_dwell, m_score, m_avg;
    logic      m_vld;
    logic [1:0] m_irq;
    int        m_win [$];
    samp_t     pend [$];

    task automatic model_reset();
        foreach (m_w[k]) m_w[k] = 0;
        m_warn = 64; m_emer = 128; m_state = 0; m_dwell = 0;
        m_score = 0; m_avg = 0; m_vld = 1'b0; m_irq = 2'b00;
        m_win.delete();
        pend.delete();
    endtask

    function automatic int model_score(input logic [31:0] f);
        int  acc = 0;
        byte fb;
        for (int k = 0; k < NF; k++) begin
            fb = f[k*8 +: 8];
            acc += int'(fb) * m_w[k];
        end
        if (acc < 0) acc = -acc;
        acc = acc / 16;
        return (acc > 255) ? 255 : acc;
    endfunction

    function automatic int model_avg(input int s);
        int tot = 0;
        m_win.push_back(s);
        if (m_win.size() > 8) void'(m_win.pop_front());
        foreach (m_win[i]) tot += m_win[i];
        return tot / 8;
    endfunction

    function automatic int clamp0(input int x);
        return (x < 0) ? 0 : x;
    endfunction

    function automatic logic [1:0] model_eval(input int a, input int s);
        logic [1:0] ev;
        ev = 2'b00;
        if (a >= m_emer || s >= m_emer) begin
            if (m_state != 2) ev[1] = 1'b1;
            m_state = 2;
            m_dwell = 0;
        end else if (m_state == 0) begin
            if (a >= m_warn) begin
                m_dwell++;
                if (m_dwell >= DWELL) begin
                    m_state = 1; m_dwell = 0; ev[0] = 1'b1;
                end
            end else begin
                m_dwell = 0;
            end
        end else if (m_state == 1) begin
            if (a < clamp0(m_warn - HYST)) m_state = 0;
        end else if (a < clamp0(m_emer - HYST)) begin
            m_state = (a < clamp0(m_warn - HYST)) ? 0 : 1;
        end
        return ev;
    endfunction

    function automatic logic [20:0] exp_vec();
        return {8'(m_score), m_vld, 8'(m_avg), 2'(m_state), m_irq};
    endfunction

    // One clock: drive inputs, advance the model at the edge, return 1ns later.
    task automatic step(input logic v, input logic [31:0] f, input logic we,
                        input logic [3:0] a, input logic [15:0] d,
                        input logic [1:0] ack, input logic [1:0] mask);
        samp_t keep [$];
        logic [1:0] ev;
        in_valid = v; feat = f; cfg_we = we; cfg_addr = a; cfg_wdata = d;
        irq_ack = ack; irq_mask = mask;
        @(posedge clk);
        ecount++;
        ev = 2'b00;
        m_vld = 1'b0;
        foreach (pend[i]) begin
            if (pend[i].cap == ecount - 1) begin
                m_score = pend[i].s; m_vld = 1'b1;
            end
            if (pend[i].cap == ecount - 2) m_avg = pend[i].a;
            if (pend[i].cap == ecount - 3) ev |= model_eval(pend[i].a, pend[i].s);
            else keep.push_back(pend[i]);
        end
        pend = keep;
        m_irq = (m_irq & ~ack) | (ev & ~mask);
        if (v) begin
            int s;
            s = model_score(f);
            pend.push_back('{ecount, s, model_avg(s)});
        end
        if (we) begin
            if (int'(a) < NF) m_w[a] = int'($signed(d[7:0]));
            else if (int'(a) == NF) m_warn = int'(d[7:0]);
            else if (int'(a) == NF + 1) m_emer = int'(d[7:0]);
        end
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        step(1'b0, '0, 1'b1, a, d, 2'b00, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; cfg_we = 1'b0; irq_ack = '0; irq_mask = '0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        if (obs !== 21'd0) begin
            $display("FAIL reset_init: got %h want 0", obs); miscompares++;
        end
        vectors++;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cfg_write(4'd0, 16'd3);
        cfg_write(4'd1, 16'hFFFB);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, $urandom, 1'b0, '0, '0, 2'b00, 2'b00);
            if (obs !== exp_vec()) begin
                $display("FAIL reset_stream i=%0d: got %h want %h", i, obs, exp_vec()); miscompares++;
            end
            vectors++;
        end
        #2 rst = 1'b0;
        #1;
        if (obs !== 21'd0) begin
            $display("FAIL reset_async: got %h want 0", obs); miscompares++;
        end
        vectors++;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cfg_write(4'd0, 16'd64);
        step(1'b1, 32'h0000_0020, 1'b0, '0, '0, 2'b00, 2'b00);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 1'b0, '0, '0, 2'b00, 2'b00);
            if (obs !== exp_vec()) begin
                $display("FAIL reset_after i=%0d: got %h want %h", i, obs, exp_vec()); miscompares++;
            end
            vectors++;
        end
        if (avg !== 8'd16) begin
            $display("FAIL reset_fresh_avg: got %0d want 16", avg); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_ramp();
        int a4 = -1;
        int wi = -1;
        logic [31:0] f;
        do_reset();
        cfg_write(4'd0, 16'd1);
        cfg_write(4'(NF), 16'd4);
        cfg_write(4'(NF + 1), 16'd255);
        for (int i = 0; i < 18; i++) begin
            f = $urandom;
            f[7:0] = 8'd64;
            step(1'b1, f, 1'b0, '0, '0, 2'b00, 2'b00);
            if (obs !== exp_vec()) begin
                $display("FAIL ramp i=%0d: got %h want %h", i, obs, exp_vec()); miscompares++;
            end
            vectors++;
            if (a4 < 0 && avg >= 8'd4) a4 = i;
            if (wi < 0 && state == 2'd1) wi = i;
        end
        if (wi - a4 !== DWELL || a4 < 0) begin
            $display("FAIL ramp_dwell: got %0d cycles want %0d", wi - a4, DWELL); miscompares++;
        end
        vectors++;
        if ({state, irq} !== {2'd1, 2'b01}) begin
            $display("FAIL ramp_final: got state %0d irq %b want 1 01", state, irq); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_negative();
        logic [31:0] f;
        do_reset();
        cfg_write(4'd0, 16'hFFFE);
        f = $urandom;
        f[7:0] = 8'd100;
        step(1'b1, f, 1'b0, '0, '0, 2'b00, 2'b00);
        step(1'b0, '0, 1'b0, '0, '0, 2'b00, 2'b00);
        if ({score, score_vld} !== {8'd12, 1'b1}) begin
            $display("FAIL neg_score: got %0d vld %b want 12 1", score, score_vld); miscompares++;
        end
        vectors++;
        for (int k = 0; k < NF; k++) cfg_write(4'(k), 16'd127);
        step(1'b1, 32'h8080_8080, 1'b0, '0, '0, 2'b00, 2'b00);
        step(1'b0, '0, 1'b0, '0, '0, 2'b00, 2'b00);
        if (score !== 8'd255) begin
            $display("FAIL neg_sat: got %0d want 255", score); miscompares++;
        end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, '0, '0, 2'b00, 2'b00);
            if (obs !== exp_vec()) begin
                $display("FAIL neg_tail i=%0d: got %h want %h", i, obs, exp_vec()); miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_bypass();
        do_reset();
        cfg_write(4'd0, 16'd100);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, (i == 12) ? 32'd32 : 32'd13, 1'b0, '0, '0, 2'b00, 2'b00);
            if (obs !== exp_vec()) begin
                $display("FAIL bypass i=%0d: got %h want %h", i, obs, exp_vec()); miscompares++;
            end
            vectors++;
            if (i == 15 && {state, irq} !== {2'd2, 2'b11}) begin
                $display("FAIL bypass_emer: got state %0d irq %b want 2 11", state, irq); miscompares++;
            end
            if (i == 15) vectors++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, '0, 2'b00, 2'b00);
        if ({state, irq} !== {2'd1, 2'b11}) begin
            $display("FAIL bypass_warn: got state %0d irq %b want 1 11", state, irq); miscompares++;
        end
        vectors++;
        step(1'b0, '0, 1'b0, '0, '0, 2'b11, 2'b00);
        if (irq !== 2'b00) begin
            $display("FAIL bypass_ack: got %b want 00", irq); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_irq();
        step(1'b1, 32'd32, 1'b0, '0, '0, 2'b00, 2'b00);
        step(1'b0, '0, 1'b0, '0, '0, 2'b00, 2'b00);
        step(1'b0, '0, 1'b0, '0, '0, 2'b00, 2'b00);
        step(1'b0, '0, 1'b0, '0, '0, 2'b10, 2'b00);
        if ({state, irq} !== {2'd2, 2'b10} || obs !== exp_vec()) begin
            $display("FAIL irq_setwins: got state %0d irq %b want 2 10", state, irq); miscompares++;
        end
        vectors++;
        step(1'b0, '0, 1'b0, '0, '0, 2'b10, 2'b00);
        if (irq !== 2'b00) begin
            $display("FAIL irq_ack: got %b want 00", irq); miscompares++;
        end
        vectors++;
        for (int i = 0; i < 5; i++) step((i < 2), 32'd13, 1'b0, '0, '0, 2'b00, 2'b00);
        if (state !== 2'd1) begin
            $display("FAIL irq_exit: got state %0d want 1", state); miscompares++;
        end
        vectors++;
        step(1'b1, 32'd32, 1'b0, '0, '0, 2'b00, 2'b10);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, '0, 2'b00, 2'b10);
        if ({state, irq} !== {2'd2, 2'b00} || obs !== exp_vec()) begin
            $display("FAIL irq_masked: got state %0d irq %b want 2 00", state, irq); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_config();
        do_reset();
        cfg_write(4'd0, 16'd16);
        for (int i = 0; i < 24; i++) begin
            if (i == 3) step(1'b1, 32'd30, 1'b1, 4'(NF), 16'd20, 2'b00, 2'b00);
            else if (i == 18) step(1'b1, 32'd30, 1'b1, 4'(NF + 2), 16'd1, 2'b00, 2'b00);
            else if (i == 19) step(1'b1, 32'd30, 1'b1, 4'd15, 16'd1, 2'b00, 2'b00);
            else step(1'b1, 32'd30, 1'b0, '0, '0, 2'b00, 2'b00);
            if (obs !== exp_vec()) begin
                $display("FAIL config i=%0d: got %h want %h", i, obs, exp_vec()); miscompares++;
            end
            vectors++;
        end
        if ({state, avg} !== {2'd1, 8'd30}) begin
            $display("FAIL config_final: got state %0d avg %0d want 1 30", state, avg); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_random();
        logic [1:0] mask = 2'b00;
        do_reset();
        for (int k = 0; k < NF; k++) cfg_write(4'(k), 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mask = 2'($urandom);
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
                 4'($urandom_range(0, 15)), 16'($urandom),
                 ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00, mask);
            if (obs !== exp_vec()) begin
                $display("FAIL random i=%0d: got %h want %h", i, obs, exp_vec()); miscompares++;
            end
            vectors++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp();
        test_negative();
        test_bypass();
        test_irq();
        test_config();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
